mem_access_stage: RTL and testbench

MEM-stage data-memory unit of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline outputs (ALU address, store data, access-width controls, write strobe, halt). It performs byte/halfword/word stores into an internal data memory and returns formatted load data to the MEM/WB register. It also zero-initialises the memory after reset with a sequential sweep, freezes stores once the program halts, and exposes a read-only debug port for the debug unit.

---
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage data memory: byte/half/word stores, formatted loads, post-reset
// zero sweep, store freeze after halt and a raw-word debug read port.
module mem_access_stage #(
  parameter int BUS_SIZE       = 32,
  parameter int DMEM_ADDR_BITS = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [2:0]                i_mem_rd_src,
  input  logic [1:0]                i_mem_wr_src,
  input  logic                      i_mem_write,
  input  logic                      i_halt,
  input  logic [BUS_SIZE-1:0]       i_alu_result,
  input  logic [BUS_SIZE-1:0]       i_bus_b,
  input  logic [DMEM_ADDR_BITS-1:0] i_debug_addr,
  output logic [BUS_SIZE-1:0]       o_mem_data,
  output logic [BUS_SIZE-1:0]       o_debug_data,
  output logic                      o_misaligned,
  output logic                      o_init_busy,
  output logic                      o_halted
);
  localparam int DEPTH = 1 << DMEM_ADDR_BITS;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALTED} state_e;

  state_e                    state_q, state_d;
  logic [DMEM_ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [BUS_SIZE-1:0]       mem_q [DEPTH];

  logic [DMEM_ADDR_BITS-1:0] idx;
  logic [1:0]                off;
  logic [BUS_SIZE-1:0]       rd_word;
  logic [7:0]                rd_byte;
  logic [15:0]               rd_half;
  logic                      st_mis, ld_mis, st_en;
  logic [NUM_LANES-1:0]      be;
  logic [BUS_SIZE-1:0]       st_data, merged;
  logic                      wr_en;
  logic [DMEM_ADDR_BITS-1:0] wr_idx;
  logic [BUS_SIZE-1:0]       wr_data;
  logic                      unused_addr;

  assign idx         = i_alu_result[DMEM_ADDR_BITS+1:2];
  assign off         = i_alu_result[1:0];
  assign unused_addr = ^i_alu_result[BUS_SIZE-1:DMEM_ADDR_BITS+2];
  assign rd_word     = mem_q[idx];
  assign rd_byte     = rd_word[8*off +: 8];
  assign rd_half     = rd_word[16*off[1] +: 16];

  // Store misalignment only counts when a store is requested; load
  // misalignment is raised from the load format alone.
  always_comb begin
    st_mis = 1'b0;
    if (i_mem_write) begin
      case (i_mem_wr_src)
        2'b00:   st_mis = 1'b0;
        2'b01:   st_mis = off[0];
        default: st_mis = (off != 2'b00);
      endcase
    end
    case (i_mem_rd_src)
      3'b000, 3'b011: ld_mis = 1'b0;
      3'b001, 3'b100: ld_mis = off[0];
      default:        ld_mis = (off != 2'b00);
    endcase
  end
  assign o_misaligned = st_mis | ld_mis;

  always_comb begin
    case (i_mem_rd_src)
      3'b000:  o_mem_data = {{(BUS_SIZE-8){rd_byte[7]}}, rd_byte};
      3'b001:  o_mem_data = {{(BUS_SIZE-16){rd_half[15]}}, rd_half};
      3'b011:  o_mem_data = {{(BUS_SIZE-8){1'b0}}, rd_byte};
      3'b100:  o_mem_data = {{(BUS_SIZE-16){1'b0}}, rd_half};
      default: o_mem_data = rd_word;
    endcase
  end

  always_comb begin
    case (i_mem_wr_src)
      2'b00: begin
        be      = 4'b0001 << off;
        st_data = {4{i_bus_b[7:0]}};
      end
      2'b01: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{i_bus_b[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = i_bus_b;
      end
    endcase
  end

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    assign merged[8*b +: 8] = be[b] ? st_data[8*b +: 8] : rd_word[8*b +: 8];
  end

  assign st_en = (state_q == ST_RUN) && i_enable && i_mem_write && !st_mis;

  // Single write port: the clear sweep owns it in INIT, stores otherwise.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = merged;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_data = '0;
    end else if (st_en) begin
      wr_en = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + DMEM_ADDR_BITS'(1);
        if (cnt_q == DMEM_ADDR_BITS'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:    if (i_enable && i_halt) state_d = ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign o_debug_data = mem_q[i_debug_addr];
  assign o_init_busy  = (state_q == ST_INIT);
  assign o_halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: clear sweep, stores, load formats,
// misalignment, enable gating, reset mid-sweep and halt freeze.
module tb_mem_access_stage;
  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_mem_write, i_halt;
  logic [2:0]  i_mem_rd_src;
  logic [1:0]  i_mem_wr_src;
  logic [31:0] i_alu_result, i_bus_b;
  logic [4:0]  i_debug_addr;
  logic [31:0] o_mem_data, o_debug_data;
  logic        o_misaligned, o_init_busy, o_halted;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_stage #(.BUS_SIZE(32), .DMEM_ADDR_BITS(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_mem_rd_src(i_mem_rd_src), .i_mem_wr_src(i_mem_wr_src),
    .i_mem_write(i_mem_write), .i_halt(i_halt),
    .i_alu_result(i_alu_result), .i_bus_b(i_bus_b),
    .i_debug_addr(i_debug_addr), .o_mem_data(o_mem_data),
    .o_debug_data(o_debug_data), .o_misaligned(o_misaligned),
    .o_init_busy(o_init_busy), .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] ws);
    i_alu_result = addr;
    i_bus_b      = data;
    i_mem_wr_src = ws;
    i_mem_rd_src = 3'b000;
    i_mem_write  = 1'b1;
    tick();
    i_mem_write  = 1'b0;
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    i_debug_addr = a;
    #1;
    check(tag, o_debug_data, exp);
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [2:0] rs,
                          input logic [31:0] exp);
    i_mem_write  = 1'b0;
    i_alu_result = addr;
    i_mem_rd_src = rs;
    #1;
    check(tag, o_mem_data, exp);
  endtask

  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    while (o_init_busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, 32);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_mem_write = 1'b0; i_halt = 1'b0;
    i_mem_rd_src = 3'b010; i_mem_wr_src = 2'b10;
    i_alu_result = '0; i_bus_b = '0; i_debug_addr = '0;
    tick(); tick();
    check("rst_busy", {31'd0, o_init_busy}, 32'd1);
    check("rst_halted", {31'd0, o_halted}, 32'd0);
    i_reset = 1'b0;
    wait_sweep("init_len0");

    // Preload, then reset clears everything again.
    store(32'h0, 32'h12345678, 2'b10);
    store(32'h7C, 32'hA5A5A5A5, 2'b10);
    dbg_chk("preload31", 5'd31, 32'hA5A5A5A5);
    i_reset = 1'b1;
    tick();
    check("rst1_busy", {31'd0, o_init_busy}, 32'd1);
    i_reset = 1'b0;
    wait_sweep("init_len1");
    for (int a = 0; a < 32; a++) dbg_chk($sformatf("clr%0d", a), 5'(a), 32'h0);

    // Byte and half stores into a word.
    store(32'h8, 32'h11223344, 2'b10);
    store(32'h9, 32'h000000AA, 2'b00);
    dbg_chk("sb_w2", 5'd2, 32'h1122AA44);
    store(32'hA, 32'h0000BEEF, 2'b01);
    dbg_chk("sh_w2", 5'd2, 32'hBEEFAA44);

    // Load formatting.
    store(32'h0, 32'h80FF7F01, 2'b10);
    load_chk("lb2",  32'h2, 3'b000, 32'hFFFFFFFF);
    load_chk("lbu3", 32'h3, 3'b011, 32'h00000080);
    load_chk("lh2",  32'h2, 3'b001, 32'hFFFF80FF);
    load_chk("lhu0", 32'h0, 3'b100, 32'h00007F01);
    load_chk("lw0",  32'h0, 3'b010, 32'h80FF7F01);
    check("lw0_mis", {31'd0, o_misaligned}, 32'd0);
    load_chk("lw2_rd", 32'h2, 3'b010, 32'h80FF7F01);
    check("lw2_mis", {31'd0, o_misaligned}, 32'd1);
    load_chk("lh3_mis_data", 32'h3, 3'b001, 32'hFFFF80FF);

    // Same-cycle store and load return the old word.
    i_alu_result = 32'h0; i_bus_b = 32'h55; i_mem_wr_src = 2'b10;
    i_mem_rd_src = 3'b010; i_mem_write = 1'b1;
    #1;
    check("rdw_old", o_mem_data, 32'h80FF7F01);
    tick();
    i_mem_write = 1'b0;
    check("rdw_new", o_mem_data, 32'h00000055);

    // Aliasing and misalignment.
    store(32'h84, 32'hCAFEF00D, 2'b10);
    dbg_chk("alias_w1", 5'd1, 32'hCAFEF00D);
    i_alu_result = 32'h6; i_bus_b = 32'hFFFFFFFF; i_mem_wr_src = 2'b10;
    i_mem_rd_src = 3'b000; i_mem_write = 1'b1;
    #1;
    check("sw6_mis", {31'd0, o_misaligned}, 32'd1);
    tick();
    i_alu_result = 32'h5; i_mem_wr_src = 2'b01;
    #1;
    check("sh5_mis", {31'd0, o_misaligned}, 32'd1);
    tick();
    i_mem_write = 1'b0;
    dbg_chk("mis_w1", 5'd1, 32'hCAFEF00D);

    // No store while the pipeline is stalled.
    i_enable = 1'b0;
    store(32'h4, 32'h0BADF00D, 2'b10);
    i_enable = 1'b1;
    dbg_chk("en0_w1", 5'd1, 32'hCAFEF00D);

    // Reset at sweep cycle 10; INIT ignores stores and halt.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("mid_busy", {31'd0, o_init_busy}, 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_alu_result = 32'h0; i_bus_b = 32'hDEADBEEF; i_mem_wr_src = 2'b10;
    i_mem_rd_src = 3'b000; i_mem_write = 1'b1; i_halt = 1'b1;
    wait_sweep("init_len2");
    i_mem_write = 1'b0; i_halt = 1'b0;
    dbg_chk("init_nost", 5'd0, 32'h0);
    dbg_chk("init_clr2", 5'd2, 32'h0);
    check("init_nohalt", {31'd0, o_halted}, 32'd0);

    // Halt freeze.
    store(32'h18, 32'h0000ABCD, 2'b10);
    i_halt = 1'b1;
    store(32'h10, 32'h1, 2'b10);
    i_halt = 1'b0;
    check("halted", {31'd0, o_halted}, 32'd1);
    store(32'h10, 32'h2, 2'b10);
    store(32'h14, 32'h77, 2'b10);
    dbg_chk("halt_w4", 5'd4, 32'h1);
    dbg_chk("halt_w5", 5'd5, 32'h0);
    dbg_chk("halt_w6", 5'd6, 32'h0000ABCD);
    load_chk("halt_lw", 32'h10, 3'b010, 32'h1);
    tick();
    check("halt_stay", {31'd0, o_halted}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
